// File: rtl/uart_mem_loader_if.sv
// Memory-write and status bundle between the serial loader and the top level.
// The loader side drives the write port and status, and reads load_en and rx.
interface uart_mem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              load_en;
    logic              rx;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [15:0]       mem_din;
    logic              busy;
    logic              done;
    logic              frame_err;
    logic [ADDR_W:0]   word_cnt;

    modport master (
        input  load_en,
        input  rx,
        output mem_we,
        output mem_adr,
        output mem_din,
        output busy,
        output done,
        output frame_err,
        output word_cnt
    );

    modport slave (
        output load_en,
        output rx,
        input  mem_we,
        input  mem_adr,
        input  mem_din,
        input  busy,
        input  done,
        input  frame_err,
        input  word_cnt
    );
endinterface

// File: rtl/uart_mem_loader.sv
// UART 8N1 program loader: byte pairs become 16-bit words written to
// block memory at sequential addresses from 0 until the memory is full.
module uart_mem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8
) (
    input  logic               clock,
    input  logic               reset,
    uart_mem_loader_if.master  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WRITE
    } state_t;

    state_t            r_state;
    logic              r_rx_meta;
    logic              r_rx_sync;
    logic              r_load_d;
    logic [CW-1:0]     r_clk_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [7:0]        r_hi;
    logic              r_phase_lo;
    logic              r_we;
    logic [ADDR_W-1:0] r_adr;
    logic [15:0]       r_din;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W:0]   r_cnt;
    logic              w_load_rise;

    assign w_load_rise = bus.load_en & ~r_load_d;

    assign bus.mem_we    = r_we;
    assign bus.mem_adr   = r_adr;
    assign bus.mem_din   = r_din;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.frame_err = r_err;
    assign bus.word_cnt  = r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_load_d  <= 1'b0;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_sync <= r_rx_meta;
            r_load_d  <= bus.load_en;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_hi       <= '0;
            r_phase_lo <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= '0;
            r_din      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else if (!bus.load_en) begin
            // Abort any frame and drop a pending high byte.
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_phase_lo <= 1'b0;
        end else if (w_load_rise) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_phase_lo <= 1'b0;
            r_adr      <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!r_done && !r_rx_sync) begin
                        r_state   <= S_START;
                        r_clk_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_clk_cnt == HALF) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                        if (r_rx_sync) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_clk_cnt == FULL) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) r_state <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_clk_cnt == FULL) begin
                        r_clk_cnt <= '0;
                        r_busy    <= 1'b0;
                        if (!r_rx_sync) begin
                            r_err      <= 1'b1;
                            r_phase_lo <= 1'b0;
                            r_state    <= S_IDLE;
                        end else if (!r_phase_lo) begin
                            r_hi       <= r_shift;
                            r_phase_lo <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_din   <= {r_hi, r_shift};
                            r_state <= S_WRITE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    // First cycle raises the strobe, second retires the word.
                    if (!r_we) begin
                        r_we <= 1'b1;
                    end else begin
                        r_we       <= 1'b0;
                        r_adr      <= r_adr + 1'b1;
                        r_cnt      <= r_cnt + 1'b1;
                        r_phase_lo <= 1'b0;
                        r_state    <= S_IDLE;
                        if (r_adr == {ADDR_W{1'b1}}) r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed and randomized UART byte streams against a word-level model
// of the loader: expected writes, address, count and sticky flags.
module tb_uart_mem_loader;
    localparam int CPB = 16;
    localparam int AW  = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    uart_mem_loader_if #(.ADDR_W(AW)) u_if ();

    uart_mem_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (u_if)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [AW+15:0] wr_q[$];
    logic [AW+15:0] exp_q[$];
    logic           busy_seen = 1'b0;

    logic [AW-1:0]  m_adr;
    int             m_cnt;
    logic           m_done;
    logic           m_err;
    logic           m_phase;
    logic [7:0]     m_hi;

    always @(negedge clock) begin
        if (u_if.mem_we) wr_q.push_back({u_if.mem_adr, u_if.mem_din});
        if (u_if.busy) busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic model_clear();
        m_adr   = '0;
        m_cnt   = 0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_phase = 1'b0;
        m_hi    = '0;
    endtask

    // Word-level view: a good byte either becomes the high half or
    // completes a word; a bad stop bit flags an error and drops the pair.
    task automatic model_byte(input logic [7:0] b, input logic ok);
        if (m_done) return;
        if (!ok) begin
            m_err   = 1'b1;
            m_phase = 1'b0;
        end else if (!m_phase) begin
            m_hi    = b;
            m_phase = 1'b1;
        end else begin
            exp_q.push_back({m_adr, m_hi, b});
            if (m_cnt == (1 << AW) - 1) m_done = 1'b1;
            m_adr   = AW'((m_cnt + 1) % (1 << AW));
            m_cnt   = m_cnt + 1;
            m_phase = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop,
                             input int gap);
        u_if.rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            u_if.rx = b[i];
            cyc(CPB);
        end
        u_if.rx = stop;
        cyc(CPB);
        u_if.rx = 1'b1;
        cyc(gap);
    endtask

    task automatic send_m(input logic [7:0] b, input logic stop,
                          input int gap);
        send_byte(b, stop, gap);
        model_byte(b, stop);
    endtask

    task automatic relaunch();
        u_if.load_en = 1'b0;
        cyc(3);
        u_if.load_en = 1'b1;
        model_clear();
        cyc(3);
    endtask

    task automatic check_all(input string tag);
        int n;
        cyc(20);
        chk({tag, "/nwrites"}, wr_q.size(), exp_q.size());
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk({tag, "/write"}, 32'(wr_q[i]), 32'(exp_q[i]));
        chk({tag, "/mem_adr"}, 32'(u_if.mem_adr), 32'(m_adr));
        chk({tag, "/word_cnt"}, 32'(u_if.word_cnt), 32'(m_cnt));
        chk({tag, "/done"}, 32'(u_if.done), 32'(m_done));
        chk({tag, "/frame_err"}, 32'(u_if.frame_err), 32'(m_err));
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/mem_we"}, 32'(u_if.mem_we), 0);
        chk({tag, "/mem_adr"}, 32'(u_if.mem_adr), 0);
        chk({tag, "/mem_din"}, 32'(u_if.mem_din), 0);
        chk({tag, "/busy"}, 32'(u_if.busy), 0);
        chk({tag, "/done"}, 32'(u_if.done), 0);
        chk({tag, "/frame_err"}, 32'(u_if.frame_err), 0);
        chk({tag, "/word_cnt"}, 32'(u_if.word_cnt), 0);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic       ok;
        u_if.load_en = 1'b0;
        u_if.rx      = 1'b1;
        model_clear();
        cyc(4);
        check_zero("reset");
        reset = 1'b1;
        cyc(3);

        // Single word
        u_if.load_en = 1'b1;
        cyc(3);
        send_m(8'h12, 1'b1, 16);
        send_m(8'h34, 1'b1, 16);
        check_all("single");
        chk("single/mem_din", 32'(u_if.mem_din), 32'h1234);

        // Asynchronous reset in the middle of a frame
        u_if.rx = 1'b0;
        cyc(40);
        chk("midframe/busy", 32'(u_if.busy), 1);
        #2 reset = 1'b0;
        #1 check_zero("async_reset");
        u_if.rx = 1'b1;
        cyc(5);
        reset = 1'b1;
        model_clear();
        cyc(100);
        check_all("post_reset");

        // Fill all addresses and wrap
        for (int i = 0; i < (1 << AW); i++) begin
            send_m(8'h00, 1'b1, $urandom_range(0, 8));
            send_m(8'(i), 1'b1, $urandom_range(0, 8));
        end
        check_all("fill");
        busy_seen = 1'b0;
        send_m(8'($urandom), 1'b1, 8);
        chk("after_done/busy_seen", 32'(busy_seen), 0);
        check_all("after_done");

        // Framing error drops the byte, then a clean pair
        relaunch();
        send_m(8'hAB, 1'b0, 24);
        send_m(8'hCD, 1'b1, 8);
        send_m(8'hEF, 1'b1, 8);
        check_all("frame_err");

        // Short glitch on rx
        relaunch();
        busy_seen = 1'b0;
        u_if.rx = 1'b0;
        cyc(4);
        u_if.rx = 1'b1;
        cyc(30);
        chk("glitch/busy_seen", 32'(busy_seen), 1);
        chk("glitch/busy", 32'(u_if.busy), 0);
        check_all("glitch");

        // Abort mid-data by dropping load_en
        send_m(8'h11, 1'b1, 8);
        fork
            send_byte(8'h56, 1'b1, 16);
            begin
                cyc(CPB * 4);
                u_if.load_en = 1'b0;
            end
        join
        m_phase = 1'b0;
        check_all("abort");
        u_if.load_en = 1'b1;
        model_clear();
        cyc(3);
        check_all("relaunch");
        a = 8'($urandom);
        b = 8'($urandom);
        send_m(a, 1'b1, 8);
        send_m(b, 1'b1, 8);
        check_all("relaunch_pair");

        // Back-to-back frames
        relaunch();
        send_m(8'hDE, 1'b1, 0);
        send_m(8'hAD, 1'b1, 0);
        send_m(8'hBE, 1'b1, 0);
        send_m(8'hEF, 1'b1, 0);
        check_all("b2b");

        // Random stream with occasional bad stop bits
        relaunch();
        for (int i = 0; i < 12; i++) begin
            ok = ($urandom_range(0, 5) != 0);
            send_m(8'($urandom), ok, ok ? $urandom_range(0, 12) : 24);
        end
        check_all("random");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
